// File: rtl/interleave_ctrl_if.sv
// interleave_ctrl_if: input/output handshakes and two-bank memory control
// for interleave_ctrl. The controller takes the slave side; the
// environment (data source, sink and bit memory) takes the master side.
interface interleave_ctrl_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int AW = $clog2(ROWS * COLS);

   logic          mode;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          wr_en;
   logic          wr_bank;
   logic [AW-1:0] wr_addr;
   logic          wr_pad;
   logic          rd_en;
   logic          rd_bank;
   logic [AW-1:0] rd_addr;
   logic          out_valid;
   logic          out_ready;
   logic          out_sof;
   logic          out_eof;

   modport slave (
      input  mode, in_valid, flush, out_ready,
      output in_ready, wr_en, wr_bank, wr_addr, wr_pad,
             rd_en, rd_bank, rd_addr, out_valid, out_sof, out_eof
   );

   modport master (
      output mode, in_valid, flush, out_ready,
      input  in_ready, wr_en, wr_bank, wr_addr, wr_pad,
             rd_en, rd_bank, rd_addr, out_valid, out_sof, out_eof
   );
endinterface

// File: rtl/interleave_ctrl.sv
// interleave_ctrl: ping-pong block interleaver controller for an external
// two-bank bit memory. Bits are written linearly into one bank while the
// other, full bank is read back in row/column-transposed order.
// mode 0 interleaves (row write, column read), mode 1 deinterleaves.
// Optional feature: define ILV_FLUSH_EN to let a flush pulse close a
// partial block by padding it with zeros (state PAD). Without the macro
// flush is ignored and wr_pad is tied low.
module interleave_ctrl #(
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input logic              clk,
   input logic              rst,
   interleave_ctrl_if.slave bus
);
   localparam int N  = ROWS * COLS;
   localparam int AW = $clog2(N);
   localparam int RB = $clog2(ROWS);
   localparam int CB = $clog2(COLS);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_addr_c;
   logic          mode_q;
   logic          eff_mode;
   logic          in_pad;
   logic          in_ready_c;
   logic          wr_fire;
   logic          wr_last;
   logic          rd_fire;
   logic          rd_last;
   logic          out_valid_q;
   logic          out_sof_q;
   logic          out_eof_q;

`ifdef ILV_FLUSH_EN
   typedef enum logic {RUN, PAD} state_t;
   state_t state;

   // Flush of a partial block switches to padding until the block closes.
   // A bank holding a partial block (wr_ptr != 0) is never full, so a
   // flush never has to wait; the full check only keeps the rule explicit.
   // A flush coinciding with the write that completes the block is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (bus.flush && (wr_ptr != '0) && !wr_last && !full[wr_bank])
                        state <= PAD;
            PAD:     if (wr_last)
                        state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign in_pad = (state == PAD);
`else
   logic unused_flush;
   assign unused_flush = bus.flush;
   assign in_pad       = 1'b0;
`endif

   // Write side: accept input while the write bank has room; padding
   // writes on its own and blocks input. Nothing is accepted during reset.
   always_comb begin
      in_ready_c = !rst && !in_pad && !full[wr_bank];
      wr_fire    = in_pad ? !full[wr_bank] : (bus.in_valid && in_ready_c);
      wr_last    = wr_fire && (wr_ptr == LAST);
   end

   // Read side: fetch when the read bank is full and the output register
   // is free or draining. The mode input is honoured only on the first
   // read of a block; after that the latched copy keeps the block coherent.
   always_comb begin
      rd_fire  = full[rd_bank] && (!out_valid_q || bus.out_ready);
      rd_last  = rd_fire && (rd_ptr == LAST);
      eff_mode = (rd_ptr == '0) ? bus.mode : mode_q;
      // With power-of-two dimensions, (k mod R)*C + k div R is a bit rotate.
      if (eff_mode)
         rd_addr_c = {rd_ptr[CB-1:0], rd_ptr[AW-1:CB]};
      else
         rd_addr_c = {rd_ptr[RB-1:0], rd_ptr[AW-1:RB]};
   end

   // Bank flags: completing a write sets, completing a read clears. The two
   // can land on the same edge; they always target different banks.
   always_comb begin
      full_nxt = full;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
   end

   // Write pointer and bank; the pointer wraps naturally since N = 2**AW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full    <= '0;
         wr_bank <= 1'b0;
         wr_ptr  <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) wr_ptr  <= wr_ptr + 1'b1;
         if (wr_last) wr_bank <= ~wr_bank;
      end
   end

   // Read pointer, bank, mode latch and the output qualifier register.
   // out_valid tracks memory data arriving one cycle after rd_en and holds
   // through back-pressure, as the memory holds its data while rd_en = 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_bank     <= 1'b0;
         rd_ptr      <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         if (rd_fire) begin
            rd_ptr      <= rd_ptr + 1'b1;
            out_valid_q <= 1'b1;
            out_sof_q   <= (rd_ptr == '0);
            out_eof_q   <= (rd_ptr == LAST);
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
         end
         if (rd_last)                    rd_bank <= ~rd_bank;
         if (rd_fire && (rd_ptr == '0))  mode_q  <= bus.mode;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.wr_en     = wr_fire;
   assign bus.wr_bank   = wr_bank;
   assign bus.wr_addr   = wr_ptr;
   assign bus.wr_pad    = in_pad;
   assign bus.rd_en     = rd_fire;
   assign bus.rd_bank   = rd_bank;
   assign bus.rd_addr   = rd_addr_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eof   = out_eof_q;

endmodule

// File: tb/tb_interleave_ctrl.sv
// tb_interleave_ctrl: bench for interleave_ctrl (4x4). Models the external
// two-bank memory with integer tokens so the output order can be tracked,
// and scores every output against a matrix-transpose reference model.
module tb_interleave_ctrl;
   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int N      = ROWS * COLS;
   localparam int PADTOK = -1;

   typedef struct { int tin; int eout; bit sof; bit eof; } vec_t;
   typedef struct { int tok; bit sof; bit eof; } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   din = 0;
   int   rdata = 0;
   int   mem [2][N];
   int   cyc = 0;

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_acc = 0;
   int   ir_drop = 0;
   int   t_last = 0;
   bit   mmode = 1'b0;

   exp_t expq[$];
   int   blk[$];
   int   out_log[$];
   int   out_cyc[$];
   int   sof_log[$];
   int   eof_log[$];
   int   pad_log[$];

   int   perm0 [N] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
   vec_t vt [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   interleave_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   interleave_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // external bit memory, one cycle read latency, data held when idle
   always @(posedge clk) begin
      if (bus.wr_en) mem[bus.wr_bank][bus.wr_addr] <= bus.wr_pad ? PADTOK : din;
      if (bus.rd_en) rdata <= mem[bus.rd_bank][bus.rd_addr];
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // reference: a full block is a matrix; mode 0 fills ROWSxCOLS by rows and
   // reads by columns, mode 1 fills COLSxROWS by rows and reads by columns
   task automatic model_close();
      int   m0 [ROWS][COLS];
      int   m1 [COLS][ROWS];
      int   seq[$];
      exp_t e;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m0[r][c] = blk[r*COLS + c];
      for (int j = 0; j < COLS; j++)
         for (int i = 0; i < ROWS; i++) m1[j][i] = blk[j*ROWS + i];
      if (!mmode) begin
         for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) seq.push_back(m0[r][c]);
      end else begin
         for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) seq.push_back(m1[j][i]);
      end
      for (int k = 0; k < N; k++) begin
         e.tok = seq[k];
         e.sof = (k == 0);
         e.eof = (k == N - 1);
         expq.push_back(e);
      end
      blk.delete();
   endtask

   task automatic model_push(input int t);
      blk.push_back(t);
      if (blk.size() == N) model_close();
   endtask

   task automatic model_pad();
      while (blk.size() < N) blk.push_back(PADTOK);
      model_close();
   endtask

   // input acceptance, pad-write log and output scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.in_valid && !bus.in_ready) ir_drop++;
         if (bus.in_valid && bus.in_ready) begin
            model_push(din);
            n_acc++;
            t_last = cyc;
         end
         if (bus.wr_en && bus.wr_pad) pad_log.push_back(int'(bus.wr_addr));
         if (bus.out_valid && bus.out_ready) begin
            out_log.push_back(rdata);
            out_cyc.push_back(cyc);
            sof_log.push_back(int'(bus.out_sof));
            eof_log.push_back(int'(bus.out_eof));
            if (expq.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               exp_t e;
               e = expq.pop_front();
               chk("out_tok", rdata, e.tok);
               chk("out_sof", int'(bus.out_sof), int'(e.sof));
               chk("out_eof", int'(bus.out_eof), int'(e.eof));
            end
         end
      end
   end

   task automatic step(input bit iv, input bit ordy, input int d);
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      din           = d;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_logs();
      out_log.delete();
      out_cyc.delete();
      sof_log.delete();
      eof_log.delete();
      pad_log.delete();
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 200 && expq.size() != 0; k++) step(1'b0, 1'b1, n_acc);
      step(1'b0, 1'b1, n_acc);
      chk({tag, "_drained"}, expq.size(), 0);
   endtask

   function automatic int map_tok(input int i);
      return perm0[i % N] + (i / N) * N;
   endfunction

   // one block from the vector table, then order, flags and latency
   task automatic run_table(input string tag);
      int lim;
      clr_logs();
      for (int i = 0; i < N; i++) step(1'b1, 1'b1, vt[i].tin);
      for (int k = 0; k < 40 && out_log.size() < N; k++) step(1'b0, 1'b1, n_acc);
      chk({tag, "_count"}, out_log.size(), N);
      lim = (out_log.size() < N) ? out_log.size() : N;
      for (int i = 0; i < lim; i++) begin
         chk({tag, "_order"}, out_log[i], vt[i].eout);
         chk({tag, "_sof"},   sof_log[i], int'(vt[i].sof));
         chk({tag, "_eof"},   eof_log[i], int'(vt[i].eof));
      end
      if (lim > 0) chk({tag, "_latency"}, out_cyc[0] - t_last, 2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base, acc0, fall_at, zeros;
      bit iv, ordy;

      for (int i = 0; i < N; i++) begin
         vt[i].tin  = i;
         vt[i].eout = perm0[i];
         vt[i].sof  = (i == 0);
         vt[i].eof  = (i == N - 1);
      end

      // reset state, with an input offered to prove nothing is written
      bus.mode = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready",  int'(bus.in_ready),  0);
      chk("rst_wr_en",     int'(bus.wr_en),     0);
      chk("rst_rd_en",     int'(bus.rd_en),     0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_sof",   int'(bus.out_sof),   0);
      chk("rst_out_eof",   int'(bus.out_eof),   0);
      chk("rst_wr_pad",    int'(bus.wr_pad),    0);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rel_in_ready",  int'(bus.in_ready),  1);
      chk("rel_wr_addr",   int'(bus.wr_addr),   0);
      chk("rel_out_valid", int'(bus.out_valid), 0);
      step(1'b0, 1'b1, 0);

      // interleave one block: table of inputs and expected read order
      mmode = 1'b0; bus.mode = 1'b0;
      run_table("ilv");
      drain("ilv");

      // deinterleave four back-to-back interleaved blocks: order restored,
      // input never stalled, output never gaps
      mmode = 1'b1; bus.mode = 1'b1;
      clr_logs();
      ir_drop = 0;
      base = n_acc;
      for (int i = 0; i < 4 * N; i++) step(1'b1, 1'b1, map_tok(n_acc));
      chk("pp_accepted", n_acc - base, 4 * N);
      chk("pp_in_ready_drops", ir_drop, 0);
      drain("pp");
      chk("pp_count", out_log.size(), 4 * N);
      for (int i = 0; i < out_log.size() && i < 4 * N; i++)
         chk("pp_restored", out_log[i], base + i);
      if (out_cyc.size() == 4 * N) chk("pp_gapless", out_cyc[4*N-1] - out_cyc[0], 4 * N - 1);

      // output stalled 40 cycles while input streams
      mmode = 1'b0; bus.mode = 1'b0;
      clr_logs();
      acc0 = n_acc;
      fall_at = -1;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, n_acc);
         if (!bus.in_ready && fall_at < 0) fall_at = n_acc - acc0;
      end
      chk("stall_fall_at", fall_at, 2 * N);
      chk("stall_accepted", n_acc - acc0, 2 * N);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_rd_en", int'(bus.rd_en), 0);
      chk("stall_rd_addr", int'(bus.rd_addr), 4);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, n_acc);
      drain("stall");
      chk("stall_count", out_log.size(), ((n_acc - acc0) / N) * N);

      // reset at bit 9 of block 2 discards everything
      rst = 1'b1;
      expq.delete(); blk.delete(); n_acc = 0; clr_logs();
      step(1'b0, 1'b1, 0);
      rst = 1'b0;
      step(1'b0, 1'b1, 0);
      for (int k = 0; k < 60 && n_acc < N + 9; k++) step(1'b1, 1'b1, n_acc);
      chk("mid_accepted", n_acc, N + 9);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      expq.delete(); blk.delete(); n_acc = 0; clr_logs();
      @(negedge clk);
      chk("mid_rst_out_valid", int'(bus.out_valid), 0);
      chk("mid_rst_rd_en", int'(bus.rd_en), 0);
      chk("mid_rst_in_ready", int'(bus.in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mid_rel_in_ready", int'(bus.in_ready), 1);
      chk("mid_rel_out_valid", int'(bus.out_valid), 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, n_acc);
      chk("mid_idle_outputs", out_log.size(), 0);
      run_table("mid");
      drain("mid");

`ifdef ILV_FLUSH_EN
      // 5 bits then flush: 11 zero-padded writes close the block
      clr_logs();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, n_acc);
      bus.flush = 1'b1; step(1'b0, 1'b1, n_acc); bus.flush = 1'b0;
      model_pad();
      chk("pad_in_ready", int'(bus.in_ready), 0);
      chk("pad_wr_en", int'(bus.wr_en), 1);
      chk("pad_wr_pad", int'(bus.wr_pad), 1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, n_acc);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, n_acc);
      drain("flush");
      chk("pad_writes", pad_log.size(), 11);
      for (int i = 0; i < pad_log.size() && i < 11; i++) chk("pad_addr", pad_log[i], 5 + i);
      zeros = 0;
      foreach (out_log[i]) if (out_log[i] == PADTOK) zeros++;
      chk("pad_out_count", out_log.size(), N);
      chk("pad_out_zeros", zeros, 11);
      // flush on an empty block does nothing
      pad_log.delete();
      bus.flush = 1'b1; step(1'b0, 1'b1, n_acc); bus.flush = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, n_acc);
      chk("flush_empty_ignored", pad_log.size(), 0);
`else
      // without the feature, flush leaves the partial block untouched
      clr_logs();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, n_acc);
      bus.flush = 1'b1; step(1'b0, 1'b1, n_acc); bus.flush = 1'b0;
      chk("noflush_wr_pad", int'(bus.wr_pad), 0);
      chk("noflush_in_ready", int'(bus.in_ready), 1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, n_acc);
      chk("noflush_pad_writes", pad_log.size(), 0);
      chk("noflush_no_output", out_log.size(), 0);
      for (int i = 0; i < 11; i++) step(1'b1, 1'b1, n_acc);
      drain("noflush");
      chk("noflush_count", out_log.size(), N);
`endif

      // random handshakes on both sides, mode changed only when idle
      for (int ph = 0; ph < 4; ph++) begin
         mmode = 1'($urandom_range(0, 1));
         bus.mode = mmode;
         for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, ordy, n_acc);
         end
         drain("rand");
      end
      chk("end_expq_empty", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
